// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter between two byte-stream requesters. Ownership
//   is granted per packet. A grant is held until the owner's last byte has been
//   serialised, or until MAX_PKT_BYTES bytes have gone out under that grant.
//   When both requesters are waiting, the one that did not own the previous
//   grant is served first. The bytes left over after a packet is cut at
//   MAX_PKT_BYTES are sent under a later grant.
//
// Parameters:
//   MAX_PKT_BYTES  maximum bytes sent per grant (1..256)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   req0_data    byte offered by requester 0
//   req0_valid   requester 0 byte present
//   req0_last    requester 0 byte ends its packet
//   req0_ready   requester 0 byte accepted this cycle (combinational)
//   req1_*       same set of ports for requester 1
//   tx_data      byte held for the transmitter
//   tx_start     one-cycle pulse that starts a transmitter frame
//   tx_busy      transmitter is serialising a frame
//   grant        one-hot current owner, 2'b00 when nobody owns the link
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned MAX_PKT_BYTES = 256
) (
    input  logic       clk,
    input  logic       reset,

    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,

    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,

    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant
);

    localparam logic [8:0] MAX_CNT = 9'(MAX_PKT_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t     r_state;
    logic       r_owner;       // 0 = requester 0, 1 = requester 1
    logic       r_last_owner;  // owner of the most recently released grant
    logic       r_last_cap;    // last flag of the byte currently in flight
    logic [8:0] r_cnt;         // bytes sent under the current grant
    logic [7:0] r_tx_data;
    logic       r_tx_start;
    logic [1:0] r_grant;

    logic       w_own_valid;
    logic [7:0] w_own_data;
    logic       w_own_last;
    logic       w_xfer;
    logic       w_winner;
    logic       w_release;

    // Owner-side view of the request interface.
    always_comb begin
        w_own_valid = req0_valid;
        w_own_data  = req0_data;
        w_own_last  = req0_last;
        if (r_owner) begin
            w_own_valid = req1_valid;
            w_own_data  = req1_data;
            w_own_last  = req1_last;
        end
    end

    // A byte moves only while SEND holds the grant and the transmitter is free.
    always_comb begin
        w_xfer = (r_state == SEND) && w_own_valid && !tx_busy;
    end

    // Arbitration: a lone requester wins; on a tie the previous owner loses.
    always_comb begin
        w_winner = req1_valid;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_owner;
        end
    end

    // The grant ends on the packet's last byte or when the per-grant cap is hit.
    always_comb begin
        w_release = r_last_cap || (r_cnt == MAX_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_last_cap   <= 1'b0;
            r_cnt        <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_grant      <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_owner <= w_winner;
                        r_grant <= w_winner ? 2'b10 : 2'b01;
                        r_state <= SEND;
                    end
                end

                SEND: begin
                    if (w_xfer) begin
                        r_tx_data  <= w_own_data;
                        r_tx_start <= 1'b1;
                        r_last_cap <= w_own_last;
                        r_cnt      <= r_cnt + 9'd1;
                        r_state    <= WAIT_BUSY;
                    end
                end

                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (w_release) begin
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_cnt        <= '0;
                            r_last_cap   <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= SEND;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_xfer && !r_owner;
    assign req1_ready = w_xfer &&  r_owner;
    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign grant      = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Instance "dut" uses the default
// MAX_PKT_BYTES; instance "dut2" uses MAX_PKT_BYTES=2. Each instance has a
// transmitter model that raises tx_busy for 10 cycles after every tx_start
// and logs each started byte together with the grant at that moment.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut signals
    logic [7:0] a0_data, a1_data;
    logic       a0_valid, a0_last, a0_ready;
    logic       a1_valid, a1_last, a1_ready;
    logic [7:0] a_tx_data;
    logic       a_tx_start, a_tx_busy;
    logic [1:0] a_grant;

    // dut2 signals
    logic [7:0] b0_data, b1_data;
    logic       b0_valid, b0_last, b0_ready;
    logic       b1_valid, b1_last, b1_ready;
    logic [7:0] b_tx_data;
    logic       b_tx_start, b_tx_busy;
    logic [1:0] b_grant;

    uart_tx_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_data  (a0_data),
        .req0_valid (a0_valid),
        .req0_last  (a0_last),
        .req0_ready (a0_ready),
        .req1_data  (a1_data),
        .req1_valid (a1_valid),
        .req1_last  (a1_last),
        .req1_ready (a1_ready),
        .tx_data    (a_tx_data),
        .tx_start   (a_tx_start),
        .tx_busy    (a_tx_busy),
        .grant      (a_grant)
    );

    uart_tx_arbiter #(.MAX_PKT_BYTES(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .req0_data  (b0_data),
        .req0_valid (b0_valid),
        .req0_last  (b0_last),
        .req0_ready (b0_ready),
        .req1_data  (b1_data),
        .req1_valid (b1_valid),
        .req1_last  (b1_last),
        .req1_ready (b1_ready),
        .tx_data    (b_tx_data),
        .tx_start   (b_tx_start),
        .tx_busy    (b_tx_busy),
        .grant      (b_grant)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- transmitter models ----------------
    int         a_cnt, b_cnt;
    logic       a_mb, b_mb;          // model busy
    logic       a_hold, b_hold;      // bench-forced busy
    logic       a_men, b_men;        // model enable
    logic [7:0] a_log[$], b_log[$];
    logic [1:0] a_own[$], b_own[$];
    int         a_grants, b_grants;
    logic [1:0] a_pg, b_pg;

    assign a_tx_busy = a_mb | a_hold;
    assign b_tx_busy = b_mb | b_hold;

    initial begin
        a_cnt = 0; a_mb = 1'b0; a_pg = 2'b00; a_grants = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                a_cnt = 0;
            end else if (a_tx_start) begin
                a_log.push_back(a_tx_data);
                a_own.push_back(a_grant);
                if (a_men) a_cnt = 10;
            end else if (a_cnt > 0) begin
                a_cnt--;
            end
            a_mb = (a_cnt != 0);
            if (a_grant != 2'b00 && a_pg == 2'b00) a_grants++;
            a_pg = a_grant;
        end
    end

    initial begin
        b_cnt = 0; b_mb = 1'b0; b_pg = 2'b00; b_grants = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                b_cnt = 0;
            end else if (b_tx_start) begin
                b_log.push_back(b_tx_data);
                b_own.push_back(b_grant);
                if (b_men) b_cnt = 10;
            end else if (b_cnt > 0) begin
                b_cnt--;
            end
            b_mb = (b_cnt != 0);
            if (b_grant != 2'b00 && b_pg == 2'b00) b_grants++;
            b_pg = b_grant;
        end
    end

    // ---------------- requester drivers ----------------
    logic [7:0] q0d[$], q1d[$], q2d[$];
    logic       q0l[$], q1l[$], q2l[$];
    logic       en0, en1;

    task automatic apply();
        a0_valid = en0 && (q0d.size() > 0);
        a0_data  = 8'h00; a0_last = 1'b0;
        if (q0d.size() > 0) begin a0_data = q0d[0]; a0_last = q0l[0]; end
        a1_valid = en1 && (q1d.size() > 0);
        a1_data  = 8'h00; a1_last = 1'b0;
        if (q1d.size() > 0) begin a1_data = q1d[0]; a1_last = q1l[0]; end
        b0_valid = (q2d.size() > 0);
        b0_data  = 8'h00; b0_last = 1'b0;
        if (q2d.size() > 0) begin b0_data = q2d[0]; b0_last = q2l[0]; end
        b1_valid = 1'b0; b1_data = 8'h00; b1_last = 1'b0;
    endtask

    // One cycle: readies seen now mean the head byte is taken at the next edge.
    task automatic step();
        logic r0, r1, r2;
        r0 = a0_ready; r1 = a1_ready; r2 = b0_ready;
        @(negedge clk);
        if (r0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
        if (r1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
        if (r2) begin void'(q2d.pop_front()); void'(q2l.pop_front()); end
        apply();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_done(input string tag, input int budget);
        int n = 0;
        while ((q0d.size() > 0 || q1d.size() > 0 || q2d.size() > 0 ||
                a_grant != 2'b00 || b_grant != 2'b00) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic clear_logs();
        a_log.delete(); a_own.delete(); b_log.delete(); b_own.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic bad;
        int   n;

        reset = 1'b0; en0 = 1'b0; en1 = 1'b0;
        a_hold = 1'b0; b_hold = 1'b0; a_men = 1'b1; b_men = 1'b1;
        apply();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_start", 32'(a_tx_start), 32'd0);
        chk("rst_tx_data",  32'(a_tx_data),  32'h00);
        chk("rst_grant",    32'(a_grant),    32'd0);
        chk("rst_ready0",   32'(a0_ready),   32'd0);
        chk("rst_ready1",   32'(a1_ready),   32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single byte 0x41: ready on +1, tx_start on +2, release at +13.
        q0d = '{8'h41}; q0l = '{1'b1}; en0 = 1'b1; en1 = 1'b1;
        apply(); #1;
        chk("s1_c0_ready0", 32'(a0_ready), 32'd0);
        step();
        chk("s1_c1_grant",  32'(a_grant),  32'h1);
        chk("s1_c1_ready0", 32'(a0_ready), 32'd1);
        chk("s1_c1_start",  32'(a_tx_start), 32'd0);
        step();
        chk("s1_c2_start",  32'(a_tx_start), 32'd1);
        chk("s1_c2_data",   32'(a_tx_data),  32'h41);
        step();
        chk("s1_c3_start",  32'(a_tx_start), 32'd0);
        repeat (9) step();
        chk("s1_c12_grant", 32'(a_grant), 32'h1);
        step();
        chk("s1_c13_grant", 32'(a_grant), 32'h0);

        // Tie after reset: req0 wins, then a second tie goes to req1.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        clear_logs();
        q0d = '{8'hA0, 8'hA1, 8'hA2, 8'hD0}; q0l = '{1'b0, 1'b0, 1'b1, 1'b1};
        q1d = '{8'h55}; q1l = '{1'b1};
        apply(); #1;
        run_done("s2_done", 400);
        chk("s2_len", 32'(a_log.size()), 32'd5);
        if (a_log.size() == 5) begin
            chk("s2_b0", 32'(a_log[0]), 32'hA0); chk("s2_o0", 32'(a_own[0]), 32'h1);
            chk("s2_b1", 32'(a_log[1]), 32'hA1); chk("s2_o1", 32'(a_own[1]), 32'h1);
            chk("s2_b2", 32'(a_log[2]), 32'hA2); chk("s2_o2", 32'(a_own[2]), 32'h1);
            chk("s2_b3", 32'(a_log[3]), 32'h55); chk("s2_o3", 32'(a_own[3]), 32'h2);
            chk("s2_b4", 32'(a_log[4]), 32'hD0); chk("s2_o4", 32'(a_own[4]), 32'h1);
        end

        // Packet lock: req1 valid throughout req0's 4-byte packet.
        clear_logs();
        q0d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; q0l = '{1'b0, 1'b0, 1'b0, 1'b1};
        q1d = '{8'h66}; q1l = '{1'b1};
        en1 = 1'b0; apply(); #1;
        step();
        chk("s3_grant0", 32'(a_grant), 32'h1);
        en1 = 1'b1; apply(); #1;
        bad = 1'b0; n = 0;
        while ((q0d.size() > 0 || q1d.size() > 0 || a_grant != 2'b00) && n < 400) begin
            if (a_grant != 2'b10 && a1_ready) bad = 1'b1;
            step();
            n++;
        end
        chk("s3_done", 32'(n < 400), 32'd1);
        chk("s3_lock", 32'(bad), 32'd0);
        chk("s3_len", 32'(a_log.size()), 32'd5);
        if (a_log.size() == 5) begin
            chk("s3_b3", 32'(a_log[3]), 32'hC3);
            chk("s3_b4", 32'(a_log[4]), 32'h66);
            chk("s3_o4", 32'(a_own[4]), 32'h2);
        end

        // Owner stall: req0 drops valid for 20 cycles mid-packet.
        clear_logs();
        q0d = '{8'hE0, 8'hE1}; q0l = '{1'b0, 1'b1};
        q1d = '{8'h77}; q1l = '{1'b1};
        apply(); #1;
        n = 0;
        while (q0d.size() != 1 && n < 20) begin step(); n++; end
        chk("s4_first", 32'(q0d.size()), 32'd1);
        en0 = 1'b0; apply(); #1;
        step();
        bad = 1'b0;
        repeat (20) begin
            step();
            if (a_grant != 2'b01 || a_tx_start || a0_ready || a1_ready) bad = 1'b1;
        end
        chk("s4_stall", 32'(bad), 32'd0);
        en0 = 1'b1; apply(); #1;
        run_done("s4_done", 400);
        chk("s4_len", 32'(a_log.size()), 32'd3);
        if (a_log.size() == 3) begin
            chk("s4_b1", 32'(a_log[1]), 32'hE1); chk("s4_o1", 32'(a_own[1]), 32'h1);
            chk("s4_b2", 32'(a_log[2]), 32'h77); chk("s4_o2", 32'(a_own[2]), 32'h2);
        end

        // tx_busy already high when SEND is entered.
        clear_logs();
        a_hold = 1'b1;
        q1d = '{8'h88}; q1l = '{1'b1};
        apply(); #1;
        step();
        chk("s5_grant", 32'(a_grant), 32'h2);
        bad = 1'b0;
        repeat (4) begin
            if (a1_ready || a_tx_start) bad = 1'b1;
            step();
        end
        chk("s5_held", 32'(bad), 32'd0);
        a_hold = 1'b0; #1;
        chk("s5_ready1", 32'(a1_ready), 32'd1);
        run_done("s5_done", 100);
        chk("s5_len", 32'(a_log.size()), 32'd1);
        if (a_log.size() == 1) chk("s5_b0", 32'(a_log[0]), 32'h88);

        // Reset while parked in WAIT_BUSY (transmitter never raises busy).
        clear_logs();
        a_men = 1'b0;
        q1d = '{8'h99}; q1l = '{1'b1};
        apply(); #1;
        repeat (4) step();
        chk("s6_pre_grant", 32'(a_grant), 32'h2);
        chk("s6_pre_data",  32'(a_tx_data), 32'h99);
        #2 reset = 1'b0;
        #1;
        chk("s6_tx_start", 32'(a_tx_start), 32'd0);
        chk("s6_tx_data",  32'(a_tx_data),  32'h00);
        chk("s6_grant",    32'(a_grant),    32'd0);
        chk("s6_ready",    32'({a0_ready, a1_ready}), 32'd0);
        @(negedge clk);
        reset = 1'b1; a_men = 1'b1;
        clear_logs();
        q1d = '{8'h5A}; q1l = '{1'b1};
        apply(); #1;
        run_done("s6_done", 100);
        chk("s6_len", 32'(a_log.size()), 32'd1);
        if (a_log.size() == 1) begin
            chk("s6_b0", 32'(a_log[0]), 32'h5A);
            chk("s6_o0", 32'(a_own[0]), 32'h2);
        end

        // Cap of 2 bytes per grant on a 5-byte packet.
        clear_logs();
        b_grants = 0;
        q2d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        q2l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply(); #1;
        run_done("s7_done", 400);
        chk("s7_grants", 32'(b_grants), 32'd3);
        chk("s7_len", 32'(b_log.size()), 32'd5);
        if (b_log.size() == 5) begin
            chk("s7_b0", 32'(b_log[0]), 32'h11);
            chk("s7_b1", 32'(b_log[1]), 32'h22);
            chk("s7_b2", 32'(b_log[2]), 32'h33);
            chk("s7_b3", 32'(b_log[3]), 32'h44);
            chk("s7_b4", 32'(b_log[4]), 32'h55);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
